// File: rtl/accel_seq_pkg.sv
// Shared types and helpers for the accelerator sequence master.
//   seq_state_e     : sequencer FSM states
//   CTRL_*          : layout of the control/start word written to the accelerator
//   pattern_byte()  : byte i of pattern word k, offset by a seed
package accel_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_WRITE_DATA = 3'd1,
      ST_WRITE_CTRL = 3'd2,
      ST_WAIT_DONE  = 3'd3,
      ST_READ_DATA  = 3'd4,
      ST_DRAIN      = 3'd5,
      ST_FINISH     = 3'd6
   } seq_state_e;

   localparam int WORD_IDX_W = 9;

   localparam logic [7:0] CTRL_START_BYTE = 8'h01;
   localparam int CTRL_START_OFS  = 0;
   localparam int CTRL_NWORDS_OFS = 1;
   localparam int CTRL_INC_OFS    = 2;

   function automatic logic [7:0] pattern_byte(input logic [WORD_IDX_W-1:0] k,
                                               input int unsigned byte_i,
                                               input int unsigned bytes_per_word,
                                               input logic [7:0] seed);
      int unsigned sum;
      sum = bytes_per_word * 32'(k) + byte_i + 32'(seed);
      return sum[7:0];
   endfunction

endpackage

// File: rtl/accel_seq_checker.sv
// Read-data checker for the sequence master.
//   clk, rst_n   : clock, async active-low reset
//   clr_i        : clear the error counter (new run accepted)
//   chk_en_i     : a read request is on the bus this cycle
//   word_idx_i   : word index of that read request
//   inc_i        : per-byte increment the accelerator is expected to apply
//   rdata_i      : read data, valid one cycle after the request
//   err_cnt_o    : saturating count of mismatching words
//   mismatch_o   : the word returned this cycle mismatches (combinational)
module accel_seq_checker
   import accel_seq_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int SEED       = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr_i,
   input  logic                  chk_en_i,
   input  logic [WORD_IDX_W-1:0] word_idx_i,
   input  logic [7:0]            inc_i,
   input  logic [DATA_WIDTH-1:0] rdata_i,
   output logic [15:0]           err_cnt_o,
   output logic                  mismatch_o
);

   localparam int BPW = DATA_WIDTH / 8;
   localparam logic [7:0] SEED_B = 8'(SEED);

   logic [DATA_WIDTH-1:0] exp_q, exp_d;
   logic                  vld_q, vld_d;
   logic [15:0]           err_q, err_d;

   // Expected word is captured alongside the request so it lines up with
   // the data returned on the following cycle.
   assign mismatch_o = vld_q && (rdata_i != exp_q);
   assign err_cnt_o  = err_q;

   always_comb begin
      vld_d = chk_en_i;
      exp_d = '0;
      for (int i = 0; i < BPW; i++) begin
         exp_d[8*i +: 8] = pattern_byte(word_idx_i, i, BPW, SEED_B) + inc_i;
      end
      err_d = err_q;
      if (clr_i) begin
         err_d = '0;
      end else if (mismatch_o && (err_q != 16'hFFFF)) begin
         err_d = err_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_q <= '0;
         vld_q <= 1'b0;
         err_q <= '0;
      end else begin
         exp_q <= exp_d;
         vld_q <= vld_d;
         err_q <= err_d;
      end
   end

endmodule

// File: rtl/accel_seq_master.sv
// Bus master that exercises the accelerator memory port: writes a pattern,
// writes the control/start word, waits for done, reads back and checks.
//   clk, rst_n          : clock, async active-low reset
//   start_i             : 1-cycle start pulse, honoured only when idle
//   num_words_i         : words per run (clamped to MAX_WORDS), sampled on start
//   increment_i         : per-byte increment, sampled on start
//   busy_o, finished_o  : run in progress / end-of-run pulse
//   pass_o, timeout_o   : result of the last run
//   err_cnt_o           : mismatching words in the last run (saturating)
//   mem_*               : memory port (rdata valid one cycle after a read)
//   accel_done_i        : accelerator done level
//
// state         | meaning
// --------------+--------------------------------------------------
// ST_IDLE       | waiting for start_i
// ST_WRITE_DATA | writing pattern word idx to the data memory
// ST_WRITE_CTRL | writing the control/start word
// ST_WAIT_DONE  | waiting for accel_done_i, timeout down-counter running
// ST_READ_DATA  | reading word idx back
// ST_DRAIN      | no request; last read word is checked
// ST_FINISH     | finished_o pulse, result flags valid
//
// All outputs are registered: next-state and next-index are resolved first,
// then the bus outputs are decoded from them.
module accel_seq_master
   import accel_seq_pkg::*;
#(
   parameter int INT_ADDR_WIDTH = 20,
   parameter int DATA_WIDTH     = 32,
   parameter int CTRL_BASE_ADDR = 0,
   parameter int DATA_BASE_ADDR = 1 << (INT_ADDR_WIDTH - 1),
   parameter int MAX_WORDS      = 256,
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int SEED           = 0
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start_i,
   input  logic [7:0]                num_words_i,
   input  logic [7:0]                increment_i,
   output logic                      busy_o,
   output logic                      finished_o,
   output logic                      pass_o,
   output logic                      timeout_o,
   output logic [15:0]               err_cnt_o,
   output logic                      mem_req_o,
   output logic [INT_ADDR_WIDTH-1:0] mem_addr_o,
   output logic                      mem_we_o,
   output logic [DATA_WIDTH/8-1:0]   mem_be_o,
   output logic [DATA_WIDTH-1:0]     mem_wdata_o,
   input  logic [DATA_WIDTH-1:0]     mem_rdata_i,
   input  logic                      accel_done_i
);

   localparam int BPW   = DATA_WIDTH / 8;
   localparam int TMR_W = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [WORD_IDX_W-1:0]     MAX_N     = WORD_IDX_W'(MAX_WORDS);
   localparam logic [TMR_W-1:0]          TMR_LOAD  = TMR_W'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0]                SEED_B    = 8'(SEED);
   localparam logic [INT_ADDR_WIDTH-1:0] DATA_BASE = INT_ADDR_WIDTH'(DATA_BASE_ADDR);
   localparam logic [INT_ADDR_WIDTH-1:0] CTRL_BASE = INT_ADDR_WIDTH'(CTRL_BASE_ADDR);

   seq_state_e                state_q, state_d;
   logic [WORD_IDX_W-1:0]     idx_q, idx_d;
   logic [WORD_IDX_W-1:0]     n_q, n_d;
   logic [7:0]                inc_q, inc_d;
   logic [TMR_W-1:0]          tmr_q, tmr_d;
   logic                      busy_q, busy_d;
   logic                      finished_q, finished_d;
   logic                      pass_q, pass_d;
   logic                      timeout_q, timeout_d;
   logic                      mem_req_q, mem_req_d;
   logic                      mem_we_q, mem_we_d;
   logic [BPW-1:0]            mem_be_q, mem_be_d;
   logic [INT_ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0]     mem_wdata_q, mem_wdata_d;

   logic chk_clr;
   logic chk_mismatch;
   logic [15:0] chk_err_cnt;

   accel_seq_checker #(
      .DATA_WIDTH (DATA_WIDTH),
      .SEED       (SEED)
   ) u_checker (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr_i      (chk_clr),
      .chk_en_i   (state_q == ST_READ_DATA),
      .word_idx_i (idx_q),
      .inc_i      (inc_q),
      .rdata_i    (mem_rdata_i),
      .err_cnt_o  (chk_err_cnt),
      .mismatch_o (chk_mismatch)
   );

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      n_d       = n_q;
      inc_d     = inc_q;
      tmr_d     = tmr_q;
      pass_d    = pass_q;
      timeout_d = timeout_q;
      chk_clr   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               chk_clr   = 1'b1;
               pass_d    = 1'b0;
               timeout_d = 1'b0;
               idx_d     = '0;
               inc_d     = increment_i;
               n_d       = (WORD_IDX_W'(num_words_i) > MAX_N) ? MAX_N : WORD_IDX_W'(num_words_i);
               if (n_d == '0) begin
                  state_d = ST_FINISH;
                  pass_d  = 1'b1;
               end else begin
                  state_d = ST_WRITE_DATA;
               end
            end
         end
         ST_WRITE_DATA: begin
            if (idx_q == n_q - WORD_IDX_W'(1)) begin
               idx_d   = '0;
               state_d = ST_WRITE_CTRL;
            end else begin
               idx_d = idx_q + WORD_IDX_W'(1);
            end
         end
         ST_WRITE_CTRL: begin
            tmr_d   = TMR_LOAD;
            state_d = ST_WAIT_DONE;
         end
         ST_WAIT_DONE: begin
            // Done wins over timeout on the terminal cycle.
            if (accel_done_i) begin
               idx_d   = '0;
               state_d = ST_READ_DATA;
            end else if (tmr_q == '0) begin
               timeout_d = 1'b1;
               state_d   = ST_FINISH;
            end else begin
               tmr_d = tmr_q - TMR_W'(1);
            end
         end
         ST_READ_DATA: begin
            if (idx_q == n_q - WORD_IDX_W'(1)) begin
               state_d = ST_DRAIN;
            end else begin
               idx_d = idx_q + WORD_IDX_W'(1);
            end
         end
         ST_DRAIN: begin
            // The last word is being checked this cycle, so include it.
            state_d = ST_FINISH;
            pass_d  = (chk_err_cnt == 16'd0) && !chk_mismatch;
         end
         ST_FINISH: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d      = (state_d != ST_IDLE);
      finished_d  = (state_d == ST_FINISH);
      mem_req_d   = 1'b0;
      mem_we_d    = 1'b0;
      mem_be_d    = '0;
      mem_addr_d  = '0;
      mem_wdata_d = '0;

      case (state_d)
         ST_WRITE_DATA: begin
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b1;
            mem_be_d   = '1;
            mem_addr_d = DATA_BASE + INT_ADDR_WIDTH'(idx_d);
            for (int i = 0; i < BPW; i++) begin
               mem_wdata_d[8*i +: 8] = pattern_byte(idx_d, i, BPW, SEED_B);
            end
         end
         ST_WRITE_CTRL: begin
            mem_req_d     = 1'b1;
            mem_we_d      = 1'b1;
            mem_be_d[2:0] = 3'b111;
            mem_addr_d    = CTRL_BASE;
            mem_wdata_d[8*CTRL_START_OFS  +: 8] = CTRL_START_BYTE;
            mem_wdata_d[8*CTRL_NWORDS_OFS +: 8] = n_d[7:0];
            mem_wdata_d[8*CTRL_INC_OFS    +: 8] = inc_d;
         end
         ST_READ_DATA: begin
            mem_req_d  = 1'b1;
            mem_addr_d = DATA_BASE + INT_ADDR_WIDTH'(idx_d);
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         n_q         <= '0;
         inc_q       <= '0;
         tmr_q       <= '0;
         busy_q      <= 1'b0;
         finished_q  <= 1'b0;
         pass_q      <= 1'b0;
         timeout_q   <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_be_q    <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         n_q         <= n_d;
         inc_q       <= inc_d;
         tmr_q       <= tmr_d;
         busy_q      <= busy_d;
         finished_q  <= finished_d;
         pass_q      <= pass_d;
         timeout_q   <= timeout_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_be_q    <= mem_be_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign busy_o      = busy_q;
   assign finished_o  = finished_q;
   assign pass_o      = pass_q;
   assign timeout_o   = timeout_q;
   assign err_cnt_o   = chk_err_cnt;
   assign mem_req_o   = mem_req_q;
   assign mem_we_o    = mem_we_q;
   assign mem_be_o    = mem_be_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_accel_seq_master.sv
module tb_accel_seq_master;

   localparam int AW   = 20;
   localparam int DW   = 32;
   localparam int BPW  = DW / 8;
   localparam int MAXW = 100;
   localparam int TMO  = 16;
   localparam int SEED = 5;
   localparam logic [AW-1:0] DBASE = AW'(1 << (AW - 1));
   localparam logic [AW-1:0] CBASE = '0;

   logic          clk;
   logic          rst_n;
   logic          start_i;
   logic [7:0]    num_words_i;
   logic [7:0]    increment_i;
   logic          busy_o, finished_o, pass_o, timeout_o;
   logic [15:0]   err_cnt_o;
   logic          mem_req_o, mem_we_o;
   logic [AW-1:0] mem_addr_o;
   logic [BPW-1:0] mem_be_o;
   logic [DW-1:0] mem_wdata_o;
   logic [DW-1:0] mem_rdata_i;
   logic          accel_done_i;

   accel_seq_master #(
      .INT_ADDR_WIDTH (AW),
      .DATA_WIDTH     (DW),
      .CTRL_BASE_ADDR (0),
      .DATA_BASE_ADDR (1 << (AW - 1)),
      .MAX_WORDS      (MAXW),
      .TIMEOUT_CYCLES (TMO),
      .SEED           (SEED)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start_i      (start_i),
      .num_words_i  (num_words_i),
      .increment_i  (increment_i),
      .busy_o       (busy_o),
      .finished_o   (finished_o),
      .pass_o       (pass_o),
      .timeout_o    (timeout_o),
      .err_cnt_o    (err_cnt_o),
      .mem_req_o    (mem_req_o),
      .mem_addr_o   (mem_addr_o),
      .mem_we_o     (mem_we_o),
      .mem_be_o     (mem_be_o),
      .mem_wdata_o  (mem_wdata_o),
      .mem_rdata_i  (mem_rdata_i),
      .accel_done_i (accel_done_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic           we;
      logic [BPW-1:0] be;
      logic [AW-1:0]  addr;
      logic [DW-1:0]  wdata;
   } txn_t;

   txn_t exp_q[$];
   txn_t mon_obs, mon_exp;
   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Memory + accelerator model
   logic [DW-1:0] mem [MAXW];
   logic [DW-1:0] acc_w;
   int            rd_idx;
   int            cyc = 0;
   int            done_delay = -1;
   int            done_cnt = -1;
   int            m_n = 0;
   logic [7:0]    m_inc = '0;
   int            corrupt_word = -1;
   logic [DW-1:0] corrupt_mask = '0;
   int            fin_cnt = 0;

   always @(posedge clk) begin
      cyc++;
      if (start_i && !busy_o) begin
         accel_done_i <= 1'b0;
         done_cnt = -1;
      end
      rd_idx = int'(mem_addr_o) - int'(DBASE);
      if (mem_req_o && mem_we_o && rd_idx >= 0 && rd_idx < MAXW)
         mem[rd_idx] <= mem_wdata_o;
      if (mem_req_o && mem_we_o && mem_addr_o == CBASE) begin
         for (int k = 0; k < m_n; k++) begin
            acc_w = mem[k];
            for (int i = 0; i < BPW; i++) acc_w[8*i +: 8] = acc_w[8*i +: 8] + m_inc;
            mem[k] <= acc_w;
         end
         done_cnt = done_delay;
      end
      if (done_cnt == 0) begin
         accel_done_i <= 1'b1;
         done_cnt = -1;
      end else if (done_cnt > 0) begin
         done_cnt--;
      end
      if (mem_req_o && !mem_we_o && rd_idx >= 0 && rd_idx < MAXW)
         mem_rdata_i <= mem[rd_idx] ^ ((rd_idx == corrupt_word) ? corrupt_mask : '0);
      else
         mem_rdata_i <= $urandom;
   end

   // Bus monitor against the scoreboard
   always @(negedge clk) begin
      if (rst_n) begin
         if (finished_o) fin_cnt++;
         if (mem_req_o) begin
            mon_obs = '{we: mem_we_o, be: mem_be_o, addr: mem_addr_o,
                        wdata: (mem_we_o ? mem_wdata_o : '0)};
            check("bus_txn_expected", 64'(exp_q.size() > 0), 64'(1));
            if (exp_q.size() > 0) begin
               mon_exp = exp_q.pop_front();
               check("bus_txn", 64'(mon_obs), 64'(mon_exp));
            end
         end
      end
   end

   int start_cyc;

   task automatic start_run(input int n, input logic [7:0] inc, input int delay, input bit reads);
      int   ne;
      txn_t t;
      ne = (n > MAXW) ? MAXW : n;
      m_n = ne;
      m_inc = inc;
      done_delay = delay;
      for (int k = 0; k < ne; k++) begin
         t = '{we: 1'b1, be: '1, addr: DBASE + AW'(k), wdata: '0};
         for (int i = 0; i < BPW; i++) t.wdata[8*i +: 8] = 8'((BPW * k + i + SEED) % 256);
         exp_q.push_back(t);
      end
      if (ne > 0) begin
         t = '{we: 1'b1, be: 4'b0111, addr: CBASE, wdata: {8'h00, inc, 8'(ne), 8'h01}};
         exp_q.push_back(t);
      end
      if (reads) begin
         for (int k = 0; k < ne; k++) begin
            t = '{we: 1'b0, be: '0, addr: DBASE + AW'(k), wdata: '0};
            exp_q.push_back(t);
         end
      end
      num_words_i = 8'(n);
      increment_i = inc;
      start_i = 1'b1;
      @(posedge clk); #1;
      start_i = 1'b0;
      start_cyc = cyc;
      if (ne > 0) check("first_write_latency", 64'({mem_req_o, mem_we_o}), 64'(2'b11));
   endtask

   task automatic wait_fin(input int max, output int edges);
      while (!finished_o && (cyc - start_cyc) < max) begin
         @(posedge clk); #1;
      end
      edges = cyc - start_cyc;
      check("finished_seen", 64'(finished_o), 64'(1));
   endtask

   task automatic check_result(input string tag, input logic p, input logic to, input logic [15:0] ec);
      check({tag, "_pass"}, 64'(pass_o), 64'(p));
      check({tag, "_timeout"}, 64'(timeout_o), 64'(to));
      check({tag, "_err_cnt"}, 64'(err_cnt_o), 64'(ec));
   endtask

   task automatic check_idle_after(input string tag);
      check({tag, "_sb_empty"}, 64'(exp_q.size()), 64'(0));
      @(posedge clk); #1;
      check({tag, "_idle"}, 64'({busy_o, finished_o}), 64'(0));
   endtask

   initial begin
      int e;
      int fin_before;
      int w;
      rst_n = 1'b0;
      start_i = 1'b0;
      num_words_i = '0;
      increment_i = '0;
      accel_done_i = 1'b0;
      #23;
      check("rst_status", 64'({busy_o, finished_o, pass_o, timeout_o}), 64'(0));
      check("rst_err", 64'(err_cnt_o), 64'(0));
      check("rst_bus", 64'({mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o}), 64'(0));
      @(negedge clk); rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // N=64, inc=1, done 10 cycles after ctrl
      start_run(64, 8'h01, 10, 1'b1);
      check("t1_busy", 64'(busy_o), 64'(1));
      wait_fin(400, e);
      check("t1_cycles", 64'(e), 64'(2 * 64 + 3 + 10));
      check_result("t1", 1'b1, 1'b0, 16'd0);
      check_idle_after("t1");
      check("t1_pass_held", 64'(pass_o), 64'(1));

      // N=4 with word 2 byte 1 corrupted, start pulse and N change mid-run
      corrupt_word = 2;
      corrupt_mask = 32'h0000_FF00;
      fin_before = fin_cnt;
      start_run(4, 8'h23, 0, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      start_i = 1'b1;
      num_words_i = 8'd20;
      @(posedge clk); #1;
      start_i = 1'b0;
      wait_fin(100, e);
      check("t2_cycles", 64'(e), 64'(2 * 4 + 3));
      check_result("t2", 1'b0, 1'b0, 16'd1);
      check_idle_after("t2");
      repeat (3) @(posedge clk);
      #1;
      check("t2_finished_once", 64'(fin_cnt - fin_before), 64'(1));
      corrupt_word = -1;

      // N=8, done never: timeout after TMO wait cycles, no reads
      start_run(8, 8'h10, -1, 1'b0);
      wait_fin(100, e);
      check("t3_cycles", 64'(e), 64'(8 + 1 + TMO));
      check_result("t3", 1'b0, 1'b1, 16'd0);
      check_idle_after("t3");

      // N=0: finished next cycle, pass, no traffic
      start_run(0, 8'h00, 0, 1'b0);
      check("t4_finished_next", 64'({finished_o, busy_o, mem_req_o}), 64'(3'b110));
      wait_fin(10, e);
      check("t4_cycles", 64'(e), 64'(0));
      check_result("t4", 1'b1, 1'b0, 16'd0);
      check_idle_after("t4");

      // N above MAX_WORDS is clamped
      start_run(200, 8'hA5, 3, 1'b1);
      wait_fin(400, e);
      check("t5_cycles", 64'(e), 64'(2 * MAXW + 3 + 3));
      check_result("t5", 1'b1, 1'b0, 16'd0);
      check_idle_after("t5");

      // Reset during READ_DATA, then a clean run
      corrupt_word = 0;
      corrupt_mask = 32'h0000_0001;
      start_run(8, 8'h03, 0, 1'b1);
      w = 0;
      while (!(mem_req_o && !mem_we_o && mem_addr_o == DBASE + AW'(3)) && w < 100) begin
         @(posedge clk); #1;
         w++;
      end
      check("t6_in_read", 64'(mem_req_o && !mem_we_o && mem_addr_o == DBASE + AW'(3)), 64'(1));
      check("t6_err_before_rst", 64'(err_cnt_o), 64'(1));
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_rst_status", 64'({busy_o, finished_o, pass_o, timeout_o}), 64'(0));
      check("t6_rst_err", 64'(err_cnt_o), 64'(0));
      check("t6_rst_bus", 64'({mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o}), 64'(0));
      exp_q.delete();
      corrupt_word = -1;
      @(negedge clk); rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      start_run(4, 8'h7F, 2, 1'b1);
      wait_fin(100, e);
      check("t6_cycles", 64'(e), 64'(2 * 4 + 3 + 2));
      check_result("t6", 1'b1, 1'b0, 16'd0);
      check_idle_after("t6");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
      $fatal(1, "watchdog expired");
   end

endmodule
